// File: rtl/rect_raster_pkg.sv
// Shared types and default sizing for the rectangle rasteriser.
package rect_raster_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_X_W      = 10;
   localparam int DEF_Y_W      = 9;
   localparam int DEF_COLOUR_W = 3;
   localparam int DEF_SCREEN_W = 320;
   localparam int DEF_SCREEN_H = 240;
endpackage

// File: rtl/raster_counter_2d.sv
// Row-major column/row walker with clear-on-load and a last-pixel flag.
module raster_counter_2d #(
   parameter int X_W = 10,
   parameter int Y_W = 9
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           load_i,
   input  logic           adv_i,
   input  logic [X_W-1:0] w_lim_i,
   input  logic [Y_W-1:0] h_lim_i,
   output logic [X_W-1:0] col_o,
   output logic [Y_W-1:0] row_o,
   output logic           last_o
);
   logic [X_W-1:0] col_q, col_d;
   logic [Y_W-1:0] row_q, row_d;
   logic           col_end_s;

   assign col_end_s = (col_q == (w_lim_i - X_W'(1)));
   assign last_o    = col_end_s && (row_q == (h_lim_i - Y_W'(1)));
   assign col_o     = col_q;
   assign row_o     = row_q;

   // Next position: clear on load, otherwise step along the row and wrap to the next
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (load_i) begin
         col_d = '0;
         row_d = '0;
      end else if (adv_i) begin
         if (col_end_s) begin
            col_d = '0;
            row_d = row_q + Y_W'(1);
         end else begin
            col_d = col_q + X_W'(1);
            row_d = row_q;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Position registers
   always_ff @(posedge clock) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end
endmodule

// File: rtl/rect_raster_engine.sv
// Rectangle rasteriser: one pixel per clock, row-major, with stall and done pulse.
// Optional screen clipping when RECT_RASTER_CLIP_EN is defined.
module rect_raster_engine
   import rect_raster_pkg::*;
#(
   parameter int X_W      = DEF_X_W,
   parameter int Y_W      = DEF_Y_W,
   parameter int COLOUR_W = DEF_COLOUR_W,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [X_W-1:0]      x0,
   input  logic [Y_W-1:0]      y0,
   input  logic [X_W-1:0]      w,
   input  logic [Y_W-1:0]      h,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic                stall,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);
   state_e              state_q;
   logic [X_W-1:0]      x0_q, w_q;
   logic [Y_W-1:0]      y0_q, h_q;
   logic [COLOUR_W-1:0] colour_q;
   logic                busy_q, done_q;
   logic [X_W-1:0]      col_s;
   logic [Y_W-1:0]      row_s;
   logic                last_s, load_s, adv_s, in_screen_s;

   assign load_s = (state_q == ST_IDLE) && start;
   assign adv_s  = (state_q == ST_RUN) && !stall;

   raster_counter_2d #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .load_i  (load_s),
      .adv_i   (adv_s),
      .w_lim_i (w_q),
      .h_lim_i (h_q),
      .col_o   (col_s),
      .row_o   (row_s),
      .last_o  (last_s)
   );

`ifdef RECT_RASTER_CLIP_EN
   // One extra bit keeps off-screen pixels from wrapping back onto the screen
   logic [X_W:0] x_full_s;
   logic [Y_W:0] y_full_s;
   assign x_full_s    = {1'b0, x0_q} + {1'b0, col_s};
   assign y_full_s    = {1'b0, y0_q} + {1'b0, row_s};
   assign in_screen_s = (x_full_s < (X_W+1)'(SCREEN_W)) && (y_full_s < (Y_W+1)'(SCREEN_H));
   assign x           = x_full_s[X_W-1:0];
   assign y           = y_full_s[Y_W-1:0];
`else
   assign in_screen_s = 1'b1;
   assign x           = x0_q + col_s;
   assign y           = y0_q + row_s;
`endif

   assign colour = colour_q;
   assign plot   = adv_s && in_screen_s;
   assign busy   = busy_q;
   assign done   = done_q;

   // Control FSM with registered busy/done and operand latching
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         colour_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  x0_q     <= x0;
                  y0_q     <= y0;
                  w_q      <= w;
                  h_q      <= h;
                  colour_q <= colour_in;
                  busy_q   <= 1'b1;
                  if ((w == '0) || (h == '0)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b0;
                  end
               end else begin
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end
            end
            ST_RUN: begin
               busy_q <= 1'b1;
               if (!stall && last_s) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  done_q  <= 1'b0;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rect_raster_engine.sv
// Directed bench for rect_raster_engine; covers wrap or clip depending on RECT_RASTER_CLIP_EN.
module tb_rect_raster_engine;
   localparam int X_W = 10;
   localparam int Y_W = 9;
   localparam int C_W = 3;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [X_W-1:0] x0 = '0;
   logic [Y_W-1:0] y0 = '0;
   logic [X_W-1:0] w = '0;
   logic [Y_W-1:0] h = '0;
   logic [C_W-1:0] colour_in = '0;
   logic           stall = 1'b0;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   logic [C_W-1:0] colour;
   logic           plot, busy, done;

   int tests_run = 0;
   int tests_failed = 0;

   int q_x[$], q_y[$], q_c[$], q_k[$];
   int done_cyc, done_cnt, idle_cyc, st_plot, st_x, st_y;

   rect_raster_engine dut (
      .clock(clock), .reset(reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
      .colour_in(colour_in), .stall(stall), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Start a rectangle and record every cycle until busy drops (cycle 1 = first after accept)
   task automatic run_rect(input int x0v, input int y0v, input int wv, input int hv, input int cv,
                           input int stall_at, input int restart_at, input int reset_at,
                           input int max_cyc);
      q_x.delete(); q_y.delete(); q_c.delete(); q_k.delete();
      done_cyc = -1; done_cnt = 0; idle_cyc = -1; st_plot = -1; st_x = -1; st_y = -1;
      @(negedge clock);
      x0 = x0v[X_W-1:0]; y0 = y0v[Y_W-1:0]; w = wv[X_W-1:0]; h = hv[Y_W-1:0];
      colour_in = cv[C_W-1:0]; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 1; k <= max_cyc; k++) begin
         stall = (k == stall_at);
         reset = (k == reset_at);
         if (k == restart_at) begin
            start = 1'b1; colour_in = 3'd2; x0 = 10'd0; y0 = 9'd0; w = 10'd1; h = 9'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         if (plot) begin
            q_x.push_back(int'(x)); q_y.push_back(int'(y));
            q_c.push_back(int'(colour)); q_k.push_back(k);
         end
         if (k == stall_at) begin
            st_plot = int'(plot); st_x = int'(x); st_y = int'(y);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (!busy) begin
            idle_cyc = k;
            break;
         end
         @(posedge clock); #1;
      end
      stall = 1'b0; reset = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      tests_run++; if (plot !== 1'b0) begin tests_failed++; $display("FAIL reset_plot got %b want 0", plot); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
      tests_run++; if (x !== 10'd0 || y !== 9'd0) begin tests_failed++; $display("FAIL reset_xy got %0d,%0d want 0,0", x, y); end
      tests_run++; if (colour !== 3'd0) begin tests_failed++; $display("FAIL reset_colour got %0d want 0", colour); end
   endtask

   task automatic test_square();
      int bad;
      run_rect(240, 50, 40, 40, 1, -1, -1, -1, 2000);
      tests_run++; if (q_x.size() != 1600) begin tests_failed++; $display("FAIL sq_count got %0d want 1600", q_x.size()); end
      if (q_x.size() == 1600) begin
         tests_run++; if (q_x[0] != 240 || q_y[0] != 50 || q_k[0] != 1) begin tests_failed++; $display("FAIL sq_first got (%0d,%0d)@%0d want (240,50)@1", q_x[0], q_y[0], q_k[0]); end
         tests_run++; if (q_x[40] != 240 || q_y[40] != 51) begin tests_failed++; $display("FAIL sq_41st got (%0d,%0d) want (240,51)", q_x[40], q_y[40]); end
         tests_run++; if (q_x[1599] != 279 || q_y[1599] != 89) begin tests_failed++; $display("FAIL sq_last got (%0d,%0d) want (279,89)", q_x[1599], q_y[1599]); end
         bad = 0;
         for (int i = 0; i < 1600; i++)
            if (q_x[i] != 240 + i % 40 || q_y[i] != 50 + i / 40 || q_c[i] != 1 || q_k[i] != i + 1) bad++;
         tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL sq_order got %0d bad pixels want 0", bad); end
      end
      tests_run++; if (done_cyc != 1601 || done_cnt != 1) begin tests_failed++; $display("FAIL sq_done got cyc %0d cnt %0d want 1601/1", done_cyc, done_cnt); end
      tests_run++; if (idle_cyc != 1602) begin tests_failed++; $display("FAIL sq_idle got %0d want 1602", idle_cyc); end
   endtask

   task automatic test_zero_size();
      run_rect(7, 7, 0, 5, 4, -1, -1, -1, 20);
      tests_run++; if (q_x.size() != 0) begin tests_failed++; $display("FAIL zero_plots got %0d want 0", q_x.size()); end
      tests_run++; if (done_cyc != 1 || idle_cyc != 2) begin tests_failed++; $display("FAIL zero_timing got done %0d idle %0d want 1/2", done_cyc, idle_cyc); end
      run_rect(7, 7, 6, 0, 4, -1, -1, -1, 20);
      tests_run++; if (q_x.size() != 0 || done_cyc != 1) begin tests_failed++; $display("FAIL zeroh got plots %0d done %0d want 0/1", q_x.size(), done_cyc); end
   endtask

   task automatic test_stall();
      int ex[6] = '{0, 1, 2, 0, 1, 2};
      int ey[6] = '{0, 0, 0, 1, 1, 1};
      int ek[6] = '{1, 3, 4, 5, 6, 7};
      int bad;
      run_rect(0, 0, 3, 2, 6, 2, -1, -1, 40);
      tests_run++; if (q_x.size() != 6) begin tests_failed++; $display("FAIL stall_count got %0d want 6", q_x.size()); end
      bad = 0;
      if (q_x.size() == 6)
         for (int i = 0; i < 6; i++)
            if (q_x[i] != ex[i] || q_y[i] != ey[i] || q_k[i] != ek[i]) bad++;
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL stall_seq got %0d bad want 0", bad); end
      tests_run++; if (st_plot != 0 || st_x != 1 || st_y != 0) begin tests_failed++; $display("FAIL stall_hold got plot %0d (%0d,%0d) want 0 (1,0)", st_plot, st_x, st_y); end
      tests_run++; if (done_cyc != 8) begin tests_failed++; $display("FAIL stall_done got %0d want 8", done_cyc); end
   endtask

   task automatic test_restart_ignored();
      int bad;
      run_rect(10, 20, 4, 3, 5, -1, 3, -1, 40);
      bad = 0;
      foreach (q_c[i]) if (q_c[i] != 5 || q_x[i] != 10 + i % 4 || q_y[i] != 20 + i / 4) bad++;
      tests_run++; if (q_x.size() != 12 || bad != 0) begin tests_failed++; $display("FAIL restart_pix got %0d plots %0d bad want 12/0", q_x.size(), bad); end
      tests_run++; if (done_cnt != 1 || done_cyc != 13 || idle_cyc != 14) begin tests_failed++; $display("FAIL restart_done got cnt %0d cyc %0d idle %0d want 1/13/14", done_cnt, done_cyc, idle_cyc); end
   endtask

   task automatic test_reset_mid_run();
      run_rect(5, 5, 20, 20, 3, -1, -1, 10, 500);
      tests_run++; if (q_x.size() != 10 || idle_cyc != 11) begin tests_failed++; $display("FAIL rstmid_stop got plots %0d idle %0d want 10/11", q_x.size(), idle_cyc); end
      tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL rstmid_nodone got %0d want 0", done_cnt); end
      run_rect(5, 5, 20, 20, 3, -1, -1, -1, 500);
      tests_run++; if (q_x.size() != 400 || done_cyc != 401) begin tests_failed++; $display("FAIL rstmid_fresh got plots %0d done %0d want 400/401", q_x.size(), done_cyc); end
   endtask

`ifdef RECT_RASTER_CLIP_EN
   task automatic test_clip();
      int bad;
      run_rect(300, 230, 40, 20, 7, -1, -1, -1, 1000);
      bad = 0;
      foreach (q_x[i]) if (q_x[i] < 300 || q_x[i] > 319 || q_y[i] < 230 || q_y[i] > 239) bad++;
      tests_run++; if (q_x.size() != 200 || bad != 0) begin tests_failed++; $display("FAIL clip_pix got %0d plots %0d bad want 200/0", q_x.size(), bad); end
      tests_run++; if (done_cyc != 801) begin tests_failed++; $display("FAIL clip_done got %0d want 801", done_cyc); end
   endtask
`else
   task automatic test_wrap();
      int ex[12] = '{1022, 1023, 0, 1, 1022, 1023, 0, 1, 1022, 1023, 0, 1};
      int ey[12] = '{510, 510, 510, 510, 511, 511, 511, 511, 0, 0, 0, 0};
      int bad;
      run_rect(1022, 510, 4, 3, 6, -1, -1, -1, 40);
      bad = 0;
      if (q_x.size() == 12)
         for (int i = 0; i < 12; i++) if (q_x[i] != ex[i] || q_y[i] != ey[i]) bad++;
      tests_run++; if (q_x.size() != 12 || bad != 0) begin tests_failed++; $display("FAIL wrap_pix got %0d plots %0d bad want 12/0", q_x.size(), bad); end
      tests_run++; if (done_cyc != 13) begin tests_failed++; $display("FAIL wrap_done got %0d want 13", done_cyc); end
   endtask
`endif

   initial begin
      test_reset();
      test_square();
      test_zero_size();
      test_stall();
      test_restart_ignored();
      test_reset_mid_run();
`ifdef RECT_RASTER_CLIP_EN
      test_clip();
`else
      test_wrap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/rect_raster_engine.md
Name: rect_raster_engine

Overview:
Parametrised rectangle rasteriser: accepts origin, width, height and colour via a start/busy handshake, then emits one pixel coordinate per clock in row-major order to the VGA adapter plot interface. Successor to the fixed 40x40 square drawer: runtime width/height, colour latching, a stall input for back-pressure, a registered done pulse and optional screen clipping. Sits between the board/game FSM and vga_adapter.

Parameters:
X_W, 10, width of x coordinate and width input
Y_W, 9, width of y coordinate and height input
COLOUR_W, 3, colour bits per pixel
SCREEN_W, 320, visible columns (used only with clipping)
SCREEN_H, 240, visible rows (used only with clipping)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request to draw; sampled only in IDLE
x0  in  X_W  top-left x, latched on accepted start
y0  in  Y_W  top-left y, latched on accepted start
w  in  X_W  rectangle width in pixels, latched on start
h  in  Y_W  rectangle height in pixels, latched on start
colour_in  in  COLOUR_W  fill colour, latched on start
stall  in  1  hold current pixel; counters frozen, plot low
x  out  X_W  pixel x = x0_q + col
y  out  Y_W  pixel y = y0_q + row
colour  out  COLOUR_W  latched colour
plot  out  1  pixel valid / write strobe
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse after last pixel

Behaviour:
- Reset: state IDLE; col, row, x0_q, y0_q, w_q, h_q, colour_q = 0; plot, busy, done = 0; x, y = 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches x0,y0,w,h,colour_in; if w==0 or h==0 -> DONE (no pixels), else -> RUN with col=row=0.
- RUN: plot = !stall (and clip-pass when enabled). Each non-stalled cycle advances: col==w_q-1 -> col=0, row+1; else col+1. On last pixel (col==w_q-1 and row==h_q-1, not stalled) -> DONE.
- DONE: done=1 for exactly one cycle, busy=1, -> IDLE.
- Latency: first plot in the cycle after start is accepted; unstalled rectangle takes w*h plot cycles, done on the following cycle; next start accepted the cycle after done.
- start in RUN/DONE ignored; inputs x0..colour_in may change freely once latched.
- x, y, colour: combinational from registered base + counters; valid whenever plot=1, don't-care otherwise but stable during stall.
- Arithmetic: x0_q+col truncated to X_W, y0_q+row truncated to Y_W (wrap-around without clipping).
- stall and last pixel same cycle: pixel held, no transition.
- reset mid-RUN: IDLE next cycle, plot low, no done pulse.

Optional Feature:
- Macro RECT_RASTER_CLIP_EN.
- Defined: sums computed one bit wider; pixel with x0_q+col >= SCREEN_W or y0_q+row >= SCREEN_H has plot=0 but still consumes its cycle (timing identical to unclipped).
- Undefined: no comparison, coordinates wrap, every non-stalled RUN cycle plots.

Decomposition:
- Package rect_raster_pkg: state enum (IDLE, RUN, DONE), default X_W/Y_W/COLOUR_W and SCREEN_W/SCREEN_H constants.
- One sub-module raster_counter_2d: col/row counter with load, advance, w/h limits and last flag; FSM and output mux stay in the top.

Test Plan:
- Start x0=240,y0=50,w=40,h=40,colour=3'b001 -> 1600 plots, first (240,50), 41st (240,51), last (279,89), done exactly 1601 cycles after start cycle, busy low next cycle.
- Start w=0,h=5 -> no plot, done the cycle after start, back to IDLE.
- w=3,h=2 with stall=1 on the 2nd RUN cycle -> sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1) unchanged, (1,0) held one extra cycle with plot low, done delayed by 1.
- Second start pulsed mid-RUN with different colour -> ignored; all pixels keep original colour, one done only.
- reset at pixel 10 of 20x20 -> plot=0, busy=0 next cycle, no done; fresh start then draws full 400 pixels.
- RECT_RASTER_CLIP_EN, x0=300,y0=230,w=40,h=20 -> plots only x 300..319, y 230..239 (200 plots), done still 801 cycles after start.
